// File: rtl/xoodoo_rdi_prng.sv
// xoodoo_rdi_prng: double-buffered xorshift64 producer of 384-bit masking randomness blocks
module xoodoo_rdi_prng #(
  parameter logic [63:0] SEED_DEFAULT = 64'h9E37_79B9_7F4A_7C15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic [63:0]  seed_i,
  input  logic         seed_valid_i,
  output logic [383:0] rdi_o,
  output logic         rdi_valid_o,
  input  logic         rdi_ready_i,
  output logic         seeded_o,
  output logic [15:0]  block_cnt_o
);
  typedef enum logic {FILL, FULL} state_t;
  state_t       state_q, state_d;
  logic [63:0]  x_q, x_d, nx;
  logic [383:0] fbuf_q, fbuf_d, rdi_q, rdi_d;
  logic [2:0]   fill_cnt_q, fill_cnt_d;
  logic         rdi_valid_q, rdi_valid_d, seeded_q, seeded_d, hs;
  logic [15:0]  block_cnt_q, block_cnt_d;
  function automatic logic [63:0] step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    return t ^ (t << 17);
  endfunction
  assign rdi_o       = rdi_q;
  assign rdi_valid_o = rdi_valid_q;
  assign seeded_o    = seeded_q;
  assign block_cnt_o = block_cnt_q;
  // Next state: reseed wins, FULL waits for a handshake to drain the buffer, FILL advances the generator
  always_comb begin
    nx          = step(x_q);
    hs          = rdi_valid_q & rdi_ready_i;
    state_d     = state_q;
    x_d         = x_q;
    fbuf_d      = fbuf_q;
    rdi_d       = rdi_q;
    fill_cnt_d  = fill_cnt_q;
    rdi_valid_d = rdi_valid_q;
    seeded_d    = 1'b1;
    block_cnt_d = block_cnt_q + {15'd0, hs};
    if (seed_valid_i) begin
      x_d         = (seed_i == 64'd0) ? SEED_DEFAULT : seed_i;
      fill_cnt_d  = 3'd0;
      state_d     = FILL;
      rdi_valid_d = 1'b0;
    end else if (state_q == FULL) begin
      if (hs) begin
        rdi_d      = fbuf_q;
        state_d    = FILL;
        fill_cnt_d = 3'd0;
      end
    end else begin
      if (hs) rdi_valid_d = 1'b0;
      if (enable_i) begin
        x_d = nx;
        fbuf_d[{fill_cnt_q, 6'd0} +: 64] = nx;
        if (fill_cnt_q == 3'd5) begin
          fill_cnt_d = 3'd0;
          if (!rdi_valid_q || hs) begin
            rdi_d       = fbuf_d;
            rdi_valid_d = 1'b1;
          end else begin
            state_d = FULL;
          end
        end else begin
          fill_cnt_d = fill_cnt_q + 3'd1;
        end
      end
    end
  end
  // State registers with asynchronous reset to the default seed and empty output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      x_q         <= SEED_DEFAULT;
      fbuf_q      <= '0;
      rdi_q       <= '0;
      fill_cnt_q  <= 3'd0;
      rdi_valid_q <= 1'b0;
      seeded_q    <= 1'b0;
      block_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      fbuf_q      <= fbuf_d;
      rdi_q       <= rdi_d;
      fill_cnt_q  <= fill_cnt_d;
      rdi_valid_q <= rdi_valid_d;
      seeded_q    <= seeded_d;
      block_cnt_q <= block_cnt_d;
    end
  end
endmodule
